// File: rtl/mux_demux_pkg.sv
// Shared types and helpers for the MUX-DEMUX route sequencer and its datapath.
package mux_demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Upper bound on a packed source map handled by map_entry().
  localparam int unsigned MAP_MAX_W = 512;

  // Width of a select that addresses n items, never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Entry j of a packed map whose entries are sw bits wide.
  function automatic int unsigned map_entry(input logic [MAP_MAX_W-1:0] map,
                                            input int unsigned          j,
                                            input int unsigned          sw);
    logic [MAP_MAX_W-1:0] shifted;
    shifted = map >> (j * sw);
    return shifted[31:0] & ((32'd1 << sw) - 32'd1);
  endfunction

endpackage

// File: rtl/mux_demux_datapath.sv
// Combinational N:1 mux feeding a 1:M demux; one source bit lands on one output bit.
module mux_demux_datapath
  import mux_demux_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned M  = 8,
  parameter int unsigned SW = sel_width(N),
  parameter int unsigned DW = sel_width(M)
) (
  input  logic [N-1:0]  data_in,
  input  logic [SW-1:0] sel_mux,
  input  logic [DW-1:0] sel_demux,
  output logic [M-1:0]  data_out
);

  logic mux_bit;

  // Selects at or beyond N yield 0, so an illegal map entry routes a zero bit.
  always_comb begin
    mux_bit = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(sel_mux) == i) mux_bit = data_in[i];
    end
  end

  always_comb begin
    data_out = '0;
    for (int unsigned j = 0; j < M; j++) begin
      if (32'(sel_demux) == j) data_out[j] = mux_bit;
    end
  end

endmodule

// File: rtl/mux_demux_route_sequencer.sv
// Accepts a word plus source map, walks the datapath one output bit per cycle,
// and presents the assembled permuted word on a valid/ready handshake.
module mux_demux_route_sequencer
  import mux_demux_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned M  = 8,
  parameter int unsigned SW = sel_width(N),
  parameter int unsigned DW = sel_width(M)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [M*SW-1:0] in_map,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  out_data,
  output logic          busy,
  output logic          map_err
);

  localparam logic [DW-1:0] LAST_STEP = DW'(M - 1);

  state_e          state_q, state_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [M-1:0]    acc_q, acc_d;
  logic [N-1:0]    data_q, data_d;
  logic [M*SW-1:0] map_q, map_d;
  logic [M-1:0]    out_data_q, out_data_d;
  logic            err_q, err_d;

  logic [SW-1:0]   sel_mux;
  logic [DW-1:0]   sel_demux;
  logic            entry_err;
  logic [M-1:0]    dp_out;

  assign sel_mux   = SW'(map_entry(MAP_MAX_W'(map_q), 32'(cnt_q), SW));
  assign sel_demux = cnt_q;
  assign entry_err = (32'(sel_mux) >= N);

  mux_demux_datapath #(
    .N (N),
    .M (M)
  ) u_datapath (
    .data_in   (data_q),
    .sel_mux   (sel_mux),
    .sel_demux (sel_demux),
    .data_out  (dp_out)
  );

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    data_d     = data_q;
    map_d      = map_q;
    out_data_d = out_data_q;
    err_d      = err_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          map_d   = in_map;
          acc_d   = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_ROUTE;
        end
      end
      ST_ROUTE: begin
        busy  = 1'b1;
        acc_d = acc_q | dp_out;
        err_d = err_q | entry_err;
        cnt_d = cnt_q + DW'(1);
        // Terminate on the last legal step, not on counter overflow.
        if (cnt_q == LAST_STEP) begin
          cnt_d      = '0;
          out_data_d = acc_q | dp_out;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; the reset here is
  // synchronous and clears the data registers too, since their reset value is observable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      data_q     <= '0;
      map_q      <= '0;
      out_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      data_q     <= data_d;
      map_q      <= map_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
    end
  end

  assign out_data = out_data_q;
  assign map_err  = err_q;

endmodule
